seg7_scan_ctrl: RTL

Parametrised N-digit multiplexed seven-segment controller. It succeeds the fixed 4-digit, 8-bit display decoder.
- Converts a captured binary magnitude to BCD sequentially (one shift/add-3 step per clock) behind a load/busy handshake.
- Scans NDIG common-anode digits, with sign, decimal point, leading-zero blanking, overflow detection and canned messages.
- Sits between the calculator datapath and the board's digit/segment pins.

---
 rtl/seg7_scan_ctrl.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: N-digit multiplexed seven-segment controller. Sequential
// binary-to-BCD conversion behind a load/busy handshake, plus a refresh scanner.
module seg7_scan_ctrl #(
    parameter int unsigned NDIG        = 4,
    parameter int unsigned BIN_W       = 8,
    parameter int unsigned REFRESH_DIV = 18
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       load,
    input  logic [BIN_W-1:0]                           bin,
    input  logic                                       sgn,
    input  logic [((NDIG > 1) ? $clog2(NDIG) : 1)-1:0] dot,
    input  logic                                       dot_en,
    input  logic                                       blank_lz,
    input  logic [1:0]                                 msg,
    output logic                                       busy,
    output logic [NDIG-1:0]                            disp_select,
    output logic [7:0]                                 disp_value
);

    localparam int unsigned IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned WORK_W = 4 * NDIG;
    localparam int unsigned CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int unsigned REF_W  = (REFRESH_DIV > 0) ? REFRESH_DIV : 1;

    localparam logic [1:0] MSG_NUM = 2'b00;
    localparam logic [1:0] MSG_OP  = 2'b01;
    localparam logic [1:0] MSG_VAL = 2'b10;
    localparam logic [1:0] MSG_ERR = 2'b11;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_O     = 8'hC0;
    localparam logic [7:0] SEG_R     = 8'hAF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_P     = 8'h8C;
    localparam logic [7:0] SEG_V     = 8'hC1;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_L     = 8'hC7;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam longint unsigned DEC_RANGE = pow10(NDIG);
    localparam longint unsigned BIN_RANGE = 64'd1 << BIN_W;

    // Reject configurations whose magnitude cannot fit the decimal digits.
    if (NDIG < 2 || NDIG > 8) begin : g_bad_ndig
        $error("seg7_scan_ctrl: NDIG=%0d outside 2..8", NDIG);
    end
    if (BIN_RANGE > DEC_RANGE) begin : g_bad_width
        $error("seg7_scan_ctrl: 2**BIN_W exceeds 10**NDIG (BIN_W=%0d NDIG=%0d)", BIN_W, NDIG);
    end

    function automatic logic [7:0] hex_glyph(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'd0:    g = 8'hC0;
            4'd1:    g = 8'hF9;
            4'd2:    g = 8'hA4;
            4'd3:    g = 8'hB0;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h92;
            4'd6:    g = 8'h82;
            4'd7:    g = 8'hF8;
            4'd8:    g = 8'h80;
            4'd9:    g = 8'h90;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Canned text, right-aligned to digit 0; characters past NDIG simply never get scanned.
    function automatic logic [7:0] text_glyph(input logic [1:0] code, input logic [31:0] pos);
        logic [7:0] g;
        g = SEG_BLANK;
        case (code)
            MSG_OP: begin
                if (pos == 32'd0) g = SEG_P;
                else if (pos == 32'd1) g = SEG_O;
            end
            MSG_VAL: begin
                if (pos == 32'd0) g = SEG_L;
                else if (pos == 32'd1) g = SEG_A;
                else if (pos == 32'd2) g = SEG_V;
            end
            MSG_ERR: begin
                if (pos == 32'd0 || pos == 32'd1) g = SEG_R;
                else if (pos == 32'd2) g = SEG_E;
            end
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_n;
    logic   capture_c, step_c, commit_c;

    logic [BIN_W-1:0]  cap_bin;
    logic [WORK_W-1:0] work;
    logic [WORK_W-1:0] adj_c;
    logic [CNT_W-1:0]  bit_cnt;
    logic              cap_sgn;
    logic [IDX_W-1:0]  cap_dot;
    logic              cap_dot_en;

    logic [WORK_W-1:0] shadow_bcd;
    logic              sh_sgn;
    logic [IDX_W-1:0]  sh_dot;
    logic              sh_dot_en;
    logic              overflow;

    logic [REF_W-1:0]  ref_cnt;
    logic [IDX_W-1:0]  idx;

    always_ff @(posedge clk or posedge rst) begin : fsm_state
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin : fsm_next
        state_n   = state;
        capture_c = 1'b0;
        step_c    = 1'b0;
        commit_c  = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    capture_c = 1'b1;
                    state_n   = CONV;
                end
            end
            CONV: begin
                step_c = 1'b1;
                if (bit_cnt == '0) state_n = COMMIT;
            end
            COMMIT: begin
                commit_c = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Add-3 correction on every nibble ahead of the shift.
    always_comb begin : bcd_adjust
        adj_c = work;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (work[4*i +: 4] > 4'd4) adj_c[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : conv_dp
        if (rst) begin
            busy       <= 1'b0;
            cap_bin    <= '0;
            work       <= '0;
            bit_cnt    <= '0;
            cap_sgn    <= 1'b0;
            cap_dot    <= '0;
            cap_dot_en <= 1'b0;
            shadow_bcd <= '0;
            sh_sgn     <= 1'b0;
            sh_dot     <= '0;
            sh_dot_en  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            busy <= (state_n != IDLE);
            if (capture_c) begin
                cap_bin    <= bin;
                cap_sgn    <= sgn;
                cap_dot    <= dot;
                cap_dot_en <= dot_en;
                work       <= '0;
                bit_cnt    <= CNT_W'(BIN_W - 1);
            end
            if (step_c) begin
                work    <= {adj_c[WORK_W-2:0], cap_bin[BIN_W-1]};
                cap_bin <= cap_bin << 1;
                bit_cnt <= bit_cnt - CNT_W'(1);
            end
            // Shadow changes only here, so the display never sees a partial value.
            if (commit_c) begin
                shadow_bcd <= work;
                sh_sgn     <= cap_sgn;
                sh_dot     <= cap_dot;
                sh_dot_en  <= cap_dot_en;
                overflow   <= (work[WORK_W-1 -: 4] != 4'd0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin : scan_cnt
        if (rst) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
            if (&ref_cnt) idx <= (idx == IDX_W'(NDIG - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

    logic [31:0]     idx32, dot32, msd, top_shown, sign_pos;
    logic            dot_valid, show_minus;
    logic [3:0]      nib_c;
    logic [NDIG-1:0] sel_c;
    logic [7:0]      num_c, glyph_c;

    // Glyph for the digit currently being scanned.
    always_comb begin : digit_decode
        idx32 = 32'(idx);
        dot32 = 32'(sh_dot);
        msd   = '0;
        nib_c = '0;
        sel_c = '1;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (idx32 == 32'(i)) begin
                nib_c    = shadow_bcd[4*i +: 4];
                sel_c[i] = 1'b0;
            end
        end
        for (int i = 0; i < int'(NDIG) - 1; i++) begin
            if (shadow_bcd[4*i +: 4] != 4'd0) msd = 32'(i);
        end
        dot_valid  = sh_dot_en && (dot32 < NDIG);
        top_shown  = (dot_valid && dot32 > msd) ? dot32 : msd;
        sign_pos   = blank_lz ? top_shown + 32'd1 : NDIG - 1;
        show_minus = sh_sgn && (shadow_bcd != '0) && (idx32 == sign_pos);

        if (idx32 == NDIG - 1)                num_c = show_minus ? SEG_MINUS : SEG_BLANK;
        else if (show_minus)                  num_c = SEG_MINUS;
        else if (blank_lz && idx32 > top_shown) num_c = SEG_BLANK;
        else                                  num_c = hex_glyph(nib_c);
        if (dot_valid && idx32 == dot32) num_c[7] = 1'b0;

        if (msg != MSG_NUM)  glyph_c = text_glyph(msg, idx32);
        else if (overflow)   glyph_c = text_glyph(MSG_ERR, idx32);
        else                 glyph_c = num_c;
    end

    always_ff @(posedge clk or posedge rst) begin : disp_out
        if (rst) begin
            disp_select <= '1;
            disp_value  <= SEG_BLANK;
        end else begin
            disp_select <= sel_c;
            disp_value  <= glyph_c;
        end
    end

endmodule
